pll_drp_sequencer: RTL and testbench
====================================

Name: pll_drp_sequencer

Overview:
- Reprograms a PLLE2_ADV at run time through its DRP port: it holds the PLL in reset, applies a table of masked read-modify-write register updates, releases reset and waits for lock.
- It sits beside the board clocking block and is driven by a CSR or MMIO front end. Typical use is switching the pixel or core clock presets.
- Its own clock must come from a source that is not the PLL under control, e.g. the buffered board input clock.

Parameters:
- DEPTH, 8, number of table entries (max RMW writes per sequence); power of two, >=2.
- DRDY_TIMEOUT, 64, cycles allowed between a DEN pulse and DRDY.
- LOCK_TIMEOUT, 65536, cycles allowed after reset release for LOCKED to rise.
- RST_HOLD, 16, minimum cycles pll_rst stays high after the final write.

Ports:
- clk  in  1  controller clock (free-running, independent of controlled PLL)
- rst_n  in  1  asynchronous active-low reset
- tbl_we  in  1  table write strobe
- tbl_idx  in  log2(DEPTH)  table entry index
- tbl_wdata  in  39  {daddr[38:32], mask[31:16], data[15:0]}; mask bit 1 = preserve old bit
- tbl_count  in  log2(DEPTH)+1  number of valid entries used by the next sequence
- start  in  1  one-cycle request to run a sequence
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence end (success or error)
- err  out  2  0 ok, 1 DRDY timeout, 2 lock timeout; sticky until the next accepted start
- locked  out  1  synchronised PLL LOCKED
- drp_daddr  out  7  DRP address
- drp_di  out  16  DRP write data
- drp_do  in  16  DRP read data
- drp_den  out  1  DRP enable, single-cycle pulse
- drp_dwe  out  1  DRP write enable, asserted only with drp_den
- drp_drdy  in  1  DRP ready
- pll_rst  out  1  PLL RST
- pll_locked  in  1  raw PLL LOCKED (asynchronous)

Behaviour:
- Reset values: busy=0, done=0, err=0, pll_rst=0, drp_den=0, drp_dwe=0, drp_daddr=0, drp_di=0, state=IDLE, entry pointer=0. Table contents are not reset.
- pll_locked passes through a 2-FF synchroniser to produce locked (2-cycle latency).
- Table writes are accepted only while busy=0. While busy=1 they are ignored. Table storage is a register array.
- start is accepted only in IDLE. On acceptance, the next cycle has busy=1, err=0, pll_rst=1. start while busy is dropped.
- FSM states: IDLE -> RD_REQ -> RD_WAIT -> WR_REQ -> WR_WAIT -> NEXT -> (RD_REQ | HOLD) -> LOCK_WAIT -> FIN -> IDLE.
  - RD_REQ: one-cycle den=1, dwe=0, daddr=entry.daddr; go to RD_WAIT.
  - RD_WAIT: on drdy, latch new = (drp_do & mask) | (data & ~mask); go to WR_REQ.
  - WR_REQ: one-cycle den=1, dwe=1, di=new; go to WR_WAIT.
  - WR_WAIT: on drdy go to NEXT.
  - NEXT: increment pointer. If pointer == tbl_count go to HOLD, else go to RD_REQ.
  - HOLD: keep pll_rst=1 for RST_HOLD cycles, then pll_rst=0 and enter LOCK_WAIT.
  - LOCK_WAIT: leave when locked=1, with err=0.
  - FIN: done=1 for one cycle, busy=0, then IDLE.
- tbl_count is sampled at start. tbl_count=0 goes straight to HOLD, giving a plain PLL reset pulse and relock. A value greater than DEPTH is clamped to DEPTH.
- The DRDY timeout counter restarts at every DEN. On expiry: err=1, abort to HOLD so the PLL is still released, then go to FIN without waiting for lock.
- The lock timeout counter starts at the LOCK_WAIT entry. On expiry: err=2, go to FIN. pll_rst stays 0.
- drdy arriving outside RD_WAIT or WR_WAIT is ignored.
- A rst_n assertion mid-sequence immediately forces the reset values, so pll_rst=0. The PLL may then be left partially reprogrammed; software must rerun the sequence.

Test Plan:
- Load entry0 = {0x08, 0x1000, 0x0145}, tbl_count=1; DRP model holds 0x1FFF at 0x08; start -> read of 0x08, then write of 0x1145. LOCKED model rises 100 cycles after release, and done pulses with err=0 no earlier than RST_HOLD+100+2 cycles after the write DRDY.
- Three entries (0x08, 0x09, 0x14), DRDY after random 1-10 cycles -> exactly 6 DEN pulses in read/write order with correct addresses; pll_rst high from start through RST_HOLD after the last write.
- DRP model never returns drdy -> 64 cycles after the first DEN, err=1 and pll_rst drops; done pulses; the next start clears err.
- LOCKED held at 0 -> done at LOCK_TIMEOUT cycles after release with err=2; locked=0.
- tbl_count=0 with start -> no DEN; pll_rst high for RST_HOLD cycles then relock. Additionally, start and tbl_we asserted while busy -> ignored, and the table is unchanged.
- rst_n pulled low during WR_WAIT -> all outputs are at reset values within the same cycle (asynchronous). After release, a new start runs normally.

Source files
------------

// File: rtl/pll_drp_sequencer.sv
// Purpose: reprograms a PLLE2_ADV over DRP. It holds the PLL in reset, applies masked
//          read-modify-write table entries, releases reset and waits for LOCKED.
// Latency: per entry, 2 DRP transactions plus 2 cycles; then a 1-cycle step, RST_HOLD cycles
//          of hold and the lock wait; done pulses 1 cycle after lock is seen.
// Backpressure: start is dropped and table writes are ignored while busy. Each DRP access
//          waits for drdy, up to DRDY_TIMEOUT cycles.
//
// Ports:
//   clk, rst_n          controller clock (not from the PLL under control), async active-low reset
//   tbl_we/idx/wdata    table write port, {daddr[38:32], mask[31:16], data[15:0]}; mask 1 = keep
//   tbl_count           number of entries used by the next sequence (clamped to DEPTH)
//   start               one-cycle request, accepted only when idle
//   busy/done/err       status: done is a 1-cycle pulse; err 0 ok, 1 DRDY timeout, 2 lock timeout
//   locked              pll_locked after a 2-FF synchroniser
//   drp_*               DRP master port
//   pll_rst, pll_locked PLL reset output and raw LOCKED input
module pll_drp_sequencer #(
    parameter int DEPTH        = 8,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int RST_HOLD     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tbl_we,
    input  logic [$clog2(DEPTH)-1:0] tbl_idx,
    input  logic [38:0]              tbl_wdata,
    input  logic [$clog2(DEPTH):0]   tbl_count,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               err,
    output logic                     locked,
    output logic [6:0]               drp_daddr,
    output logic [15:0]              drp_di,
    input  logic [15:0]              drp_do,
    output logic                     drp_den,
    output logic                     drp_dwe,
    input  logic                     drp_drdy,
    output logic                     pll_rst,
    input  logic                     pll_locked
);
    localparam int IW     = $clog2(DEPTH);
    localparam int CMAX_A = (DRDY_TIMEOUT > RST_HOLD) ? DRDY_TIMEOUT : RST_HOLD;
    localparam int CMAX   = (LOCK_TIMEOUT > CMAX_A) ? LOCK_TIMEOUT : CMAX_A;
    localparam int CW     = $clog2(CMAX + 1);

    localparam logic [IW:0]   DEPTH_C   = (IW+1)'(DEPTH);
    localparam logic [IW:0]   PTR_ONE   = (IW+1)'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] DRDY_LAST = CW'(DRDY_TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);

    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_DRDY = 2'd1;
    localparam logic [1:0] ERR_LOCK = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_NEXT,
        S_HOLD,
        S_LOCK_WAIT,
        S_FIN
    } state_t;

    state_t         state_q, state_d;
    logic [IW:0]    ptr_q, ptr_d;
    logic [IW:0]    num_q, num_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     err_q, err_d;
    logic           pll_rst_q, pll_rst_d;
    logic           den_q, den_d;
    logic           dwe_q, dwe_d;
    logic [6:0]     daddr_q, daddr_d;
    logic [15:0]    di_q, di_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           lock_meta_q, lock_sync_q;

    logic [38:0]    tbl_q [DEPTH];
    logic [38:0]    cur_ent;
    logic [38:0]    nxt_ent;
    logic [38:0]    first_ent;
    logic [IW:0]    ptr_inc;
    logic [IW:0]    count_clamped;
    logic [15:0]    merged;

    // LOCKED is asynchronous to clk; two flops before anything looks at it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked;
            lock_sync_q <= lock_meta_q;
        end
    end

    // Table is plain storage, not reset. Frozen while a sequence runs so the
    // entries being applied cannot change underneath the FSM. A write in the
    // same cycle as an accepted start lands, but entry 0's address is fetched
    // from the old contents for that first read.
    always_ff @(posedge clk) begin
        if (tbl_we && !busy_q) begin
            tbl_q[tbl_idx] <= tbl_wdata;
        end
    end

    assign ptr_inc       = ptr_q + PTR_ONE;
    assign cur_ent       = tbl_q[ptr_q[IW-1:0]];
    assign nxt_ent       = tbl_q[ptr_inc[IW-1:0]];
    assign first_ent     = tbl_q[0];
    assign count_clamped = (tbl_count > DEPTH_C) ? DEPTH_C : tbl_count;
    // Mask bit 1 keeps the bit read back from the PLL, 0 takes the table data.
    assign merged        = (drp_do & cur_ent[31:16]) | (cur_ent[15:0] & ~cur_ent[31:16]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            num_q     <= '0;
            cnt_q     <= '0;
            err_q     <= ERR_OK;
            pll_rst_q <= 1'b0;
            den_q     <= 1'b0;
            dwe_q     <= 1'b0;
            daddr_q   <= '0;
            di_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            num_q     <= num_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            pll_rst_q <= pll_rst_d;
            den_q     <= den_d;
            dwe_q     <= dwe_d;
            daddr_q   <= daddr_d;
            di_q      <= di_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Outputs are registered: den/dwe/daddr/di are set up on the transition
    // into a request state so they are valid for exactly that state's cycle.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        num_d     = num_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        pll_rst_d = pll_rst_q;
        den_d     = 1'b0;
        dwe_d     = 1'b0;
        daddr_d   = daddr_q;
        di_d      = di_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d     = ERR_OK;
                    pll_rst_d = 1'b1;
                    ptr_d     = '0;
                    num_d     = count_clamped;
                    cnt_d     = '0;
                    if (count_clamped == '0) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_RD_REQ;
                        den_d   = 1'b1;
                        daddr_d = first_ent[38:32];
                    end
                end
            end
            S_RD_REQ: begin
                // Count cycles since the DEN pulse; the wait state sees 1 first.
                cnt_d   = CNT_ONE;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (drp_drdy) begin
                    di_d    = merged;
                    den_d   = 1'b1;
                    dwe_d   = 1'b1;
                    state_d = S_WR_REQ;
                end else if (cnt_q == DRDY_LAST) begin
                    err_d   = ERR_DRDY;
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WR_REQ: begin
                cnt_d   = CNT_ONE;
                state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (drp_drdy) begin
                    state_d = S_NEXT;
                end else if (cnt_q == DRDY_LAST) begin
                    err_d   = ERR_DRDY;
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_NEXT: begin
                ptr_d = ptr_inc;
                if (ptr_inc == num_q) begin
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    den_d   = 1'b1;
                    daddr_d = nxt_ent[38:32];
                    state_d = S_RD_REQ;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    // Release the PLL even after a DRP failure so it is not
                    // left stuck in reset; only then skip the lock wait.
                    pll_rst_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = (err_q == ERR_DRDY) ? S_FIN : S_LOCK_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_LOCK_WAIT: begin
                if (lock_sync_q) begin
                    state_d = S_FIN;
                end else if (cnt_q == LOCK_LAST) begin
                    err_d   = ERR_LOCK;
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_FIN: begin
                ptr_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                pll_rst_d = 1'b0;
            end
        endcase
    end

    // busy already drops in the done cycle, so software polling busy and a
    // done-triggered interrupt agree on when the sequence ended.
    assign busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
    assign done_d = (state_d == S_FIN);

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign locked    = lock_sync_q;
    assign drp_daddr = daddr_q;
    assign drp_di    = di_q;
    assign drp_den   = den_q;
    assign drp_dwe   = dwe_q;
    assign pll_rst   = pll_rst_q;

endmodule

// File: tb/tb_pll_drp_sequencer.sv
// Bench for pll_drp_sequencer: DRP memory model and PLL lock model, an expected
// DRP transaction queue built from the table and memory, per-cycle checks in
// one negedge process, and directed tests with hand-computed timing.
module tb_pll_drp_sequencer;
    localparam int DEPTH   = 8;
    localparam int DRDY_TO = 64;
    localparam int LOCK_TO = 300;
    localparam int HOLD    = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tbl_we = 1'b0;
    logic [2:0]  tbl_idx = '0;
    logic [38:0] tbl_wdata = '0;
    logic [3:0]  tbl_count = '0;
    logic        start = 1'b0;
    logic        busy, done, locked;
    logic [1:0]  err;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_den, drp_dwe, drp_drdy;
    logic        pll_rst, pll_locked;

    pll_drp_sequencer #(
        .DEPTH(DEPTH), .DRDY_TIMEOUT(DRDY_TO), .LOCK_TIMEOUT(LOCK_TO), .RST_HOLD(HOLD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_wdata(tbl_wdata),
        .tbl_count(tbl_count), .start(start), .busy(busy), .done(done), .err(err),
        .locked(locked), .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_do(drp_do),
        .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_drdy(drp_drdy), .pll_rst(pll_rst),
        .pll_locked(pll_locked)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [6:0]  a;
        logic [15:0] d;
    } txn_t;

    logic [15:0] mem [128];
    logic [38:0] tbl_m [DEPTH];
    txn_t        exp_q [$];
    txn_t        t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int drdy_min = 1, drdy_max = 1;
    bit drdy_never = 0;
    int lock_delay = 100;
    bit lock_never = 0;

    int den_cnt, first_den_cyc, last_wr_drdy_cyc, rst_fall_cyc, rst_hi_cnt, done_cnt;
    bit wr_den_seen;

    bit          pend;
    int          cd;
    logic        pend_we;
    logic [6:0]  pend_a;
    logic [15:0] pend_d;
    int          rel_cnt;
    logic        h1, h2;
    logic        prev_den, prev_done, prev_rst;
    int          since_rst;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Compare process plus DRP and PLL models, all at the negedge so sampling
    // is away from the DUT's active edge and model updates are ordered.
    initial begin
        drp_drdy   = 1'b0;
        drp_do     = '0;
        pll_locked = 1'b1;
        pend = 0; cd = 0; rel_cnt = 0; h1 = 0; h2 = 0;
        prev_den = 0; prev_done = 0; prev_rst = 0; since_rst = 0;
        forever begin
            @(negedge clk);
            drp_drdy = 1'b0;
            if (!rst_n) begin
                pend = 0; since_rst = 0;
                prev_den = 0; prev_done = 0; prev_rst = 0;
            end else begin
                since_rst++;
                if (since_rst > 3) chk("locked_sync", locked, h2);
                if (drp_dwe) chk("dwe_only_with_den", drp_den, 1);
                if (pll_rst) chk("pll_rst_implies_busy", busy, 1);
                if (done) begin
                    done_cnt++;
                    chk("done_single_cycle", prev_done, 0);
                    chk("done_not_busy", busy, 0);
                end
                if (pll_rst) rst_hi_cnt++;
                if (prev_rst && !pll_rst) rst_fall_cyc = cyc;
                if (drp_den) begin
                    den_cnt++;
                    if (den_cnt == 1) first_den_cyc = cyc;
                    if (drp_dwe) wr_den_seen = 1;
                    chk("den_single_cycle", prev_den, 0);
                    chk("den_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        t = exp_q.pop_front();
                        chk("den_we", drp_dwe, t.we);
                        chk("den_addr", drp_daddr, t.a);
                        if (t.we) chk("den_wdata", drp_di, t.d);
                    end
                    pend = 1; cd = $urandom_range(drdy_max, drdy_min);
                    pend_we = drp_dwe; pend_a = drp_daddr; pend_d = drp_di;
                end else if (pend && !drdy_never) begin
                    cd--;
                    if (cd == 0) begin
                        drp_drdy = 1'b1;
                        pend = 0;
                        if (pend_we) begin
                            mem[pend_a] = pend_d;
                            drp_do = 16'hDEAD;
                            last_wr_drdy_cyc = cyc;
                        end else begin
                            drp_do = mem[pend_a];
                        end
                    end
                end
                prev_den = drp_den; prev_done = done; prev_rst = pll_rst;
            end
            if (pll_rst) begin
                pll_locked = 1'b0;
                rel_cnt = 0;
            end else if (!pll_locked && !lock_never) begin
                rel_cnt++;
                if (rel_cnt >= lock_delay) pll_locked = 1'b1;
            end
            h2 = h1; h1 = pll_locked;
        end
    end

    task automatic prep();
        den_cnt = 0; first_den_cyc = -1; last_wr_drdy_cyc = -1; rst_fall_cyc = -1;
        rst_hi_cnt = 0; done_cnt = 0; wr_den_seen = 0;
    endtask

    task automatic tbl_write(input int idx, input logic [6:0] a, input logic [15:0] m,
                             input logic [15:0] d);
        @(posedge clk); #1;
        tbl_we = 1'b1; tbl_idx = idx[2:0]; tbl_wdata = {a, m, d};
        tbl_m[idx] = {a, m, d};
        @(posedge clk); #1;
        tbl_we = 1'b0;
    endtask

    // Expected DRP traffic: per entry a read then a merged write.
    task automatic expect_seq(input int n);
        logic [6:0]  a;
        logic [15:0] m, d, nv;
        for (int i = 0; i < n; i++) begin
            {a, m, d} = tbl_m[i];
            nv = (mem[a] & m) | (d & ~m);
            exp_q.push_back({1'b0, a, 16'h0000});
            exp_q.push_back({1'b1, a, nv});
        end
    endtask

    task automatic do_start(input int cnt, output int scyc);
        @(posedge clk); #1;
        tbl_count = cnt[3:0]; start = 1'b1; scyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        chk(name, dcyc >= 0, 1);
    endtask

    task automatic chk_started(input string name);
        @(negedge clk);
        chk({name, "_busy"}, busy, 1);
        chk({name, "_pll_rst"}, pll_rst, 1);
        chk({name, "_err_clear"}, err, 0);
    endtask

    int s, d, ecyc;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_pll_rst", pll_rst, 0);
        chk("rst_den", drp_den, 0);
        chk("rst_dwe", drp_dwe, 0);
        chk("rst_daddr", drp_daddr, 0);
        chk("rst_di", drp_di, 0);
        chk("rst_locked", locked, 0);

        // T1: single entry, 0x1FFF merged with data 0x0145 under mask 0x1000 -> 0x1145
        prep();
        mem[7'h08] = 16'h1FFF;
        drdy_min = 3; drdy_max = 3; lock_delay = 100;
        tbl_write(0, 7'h08, 16'h1000, 16'h0145);
        exp_q.push_back({1'b0, 7'h08, 16'h0000});
        exp_q.push_back({1'b1, 7'h08, 16'h1145});
        do_start(1, s);
        chk_started("t1");
        wait_done("t1_done", 500, d);
        chk("t1_err", err, 0);
        chk("t1_locked", locked, 1);
        chk("t1_done_not_early", (d - last_wr_drdy_cyc) >= (HOLD + 100 + 2), 1);
        // one NEXT cycle, then RST_HOLD cycles of hold, after the write DRDY
        chk("t1_rst_release", rst_fall_cyc - last_wr_drdy_cyc, HOLD + 2);
        chk("t1_mem", mem[7'h08], 16'h1145);
        chk("t1_den_cnt", den_cnt, 2);
        chk("t1_queue_empty", exp_q.size(), 0);

        // T2: three entries, random DRDY latency 1..10
        prep();
        mem[7'h08] = 16'hA5A5; mem[7'h09] = 16'h0F0F; mem[7'h14] = 16'hFFFF;
        drdy_min = 1; drdy_max = 10; lock_delay = 30;
        tbl_write(0, 7'h08, 16'hFF00, 16'h1234);
        tbl_write(1, 7'h09, 16'h0000, 16'hBEEF);
        tbl_write(2, 7'h14, 16'hF0F0, 16'h0A0A);
        expect_seq(3);
        do_start(3, s);
        chk_started("t2");
        wait_done("t2_done", 800, d);
        chk("t2_err", err, 0);
        chk("t2_den_cnt", den_cnt, 6);
        chk("t2_queue_empty", exp_q.size(), 0);
        chk("t2_mem08", mem[7'h08], 16'hA534);
        chk("t2_mem09", mem[7'h09], 16'hBEEF);
        chk("t2_mem14", mem[7'h14], 16'hFAFA);
        chk("t2_rst_release", rst_fall_cyc - last_wr_drdy_cyc, HOLD + 2);
        chk("t2_rst_continuous", rst_hi_cnt, rst_fall_cyc - s - 1);

        // T3: DRP never answers
        prep();
        drdy_never = 1; drdy_min = 2; drdy_max = 2;
        mem[7'h10] = 16'h0000;
        tbl_write(0, 7'h10, 16'h00FF, 16'h5500);
        exp_q.push_back({1'b0, 7'h10, 16'h0000});
        do_start(1, s);
        chk_started("t3");
        ecyc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (err != 2'd0) begin
                ecyc = cyc;
                break;
            end
        end
        chk("t3_err_seen", ecyc >= 0, 1);
        chk("t3_err_timing", ecyc - first_den_cyc, DRDY_TO);
        chk("t3_err_val", err, 1);
        chk("t3_rst_still_high", pll_rst, 1);
        wait_done("t3_done", 100, d);
        chk("t3_done_timing", d - first_den_cyc, DRDY_TO + HOLD);
        chk("t3_rst_fall_at_done", rst_fall_cyc, d);
        chk("t3_den_cnt", den_cnt, 1);
        repeat (3) @(negedge clk);
        chk("t3_err_sticky", err, 1);
        drdy_never = 0;

        // T4: LOCKED never rises; start also clears the sticky DRDY error
        prep();
        lock_never = 1;
        mem[7'h10] = 16'h1234;
        expect_seq(1);
        do_start(1, s);
        chk_started("t4");
        wait_done("t4_done", LOCK_TO + 200, d);
        chk("t4_err", err, 2);
        chk("t4_done_timing", d - rst_fall_cyc, LOCK_TO);
        chk("t4_locked", locked, 0);
        chk("t4_pll_rst", pll_rst, 0);
        chk("t4_queue_empty", exp_q.size(), 0);
        lock_never = 0; lock_delay = 20;

        // T5: tbl_count=0 is a plain reset pulse; start/tbl_we while busy ignored
        prep();
        do_start(0, s);
        chk_started("t5");
        repeat (3) @(posedge clk);
        #1 tbl_we = 1'b1; tbl_idx = 3'd0; tbl_wdata = {7'h7F, 16'h0000, 16'hFFFF};
        start = 1'b1; tbl_count = 4'd2;
        @(posedge clk); #1;
        tbl_we = 1'b0; start = 1'b0;
        wait_done("t5_done", 200, d);
        chk("t5_err", err, 0);
        chk("t5_no_den", den_cnt, 0);
        chk("t5_rst_release", rst_fall_cyc - s, HOLD + 1);
        chk("t5_rst_cycles", rst_hi_cnt, HOLD);
        repeat (5) @(negedge clk);
        chk("t5_stays_idle", busy, 0);
        chk("t5_one_done", done_cnt, 1);

        // T6: count 15 clamps to all 8 entries; entry 0 must still be the T3 entry
        prep();
        drdy_min = 1; drdy_max = 4;
        for (int i = 1; i < DEPTH; i++) begin
            mem[7'h20 + i] = 16'h3C00 + 16'(i);
            tbl_write(i, 7'(7'h20 + i), 16'hFF00 >> i, 16'h00A0 + 16'(i));
        end
        expect_seq(DEPTH);
        do_start(15, s);
        chk_started("t6");
        wait_done("t6_done", 1500, d);
        chk("t6_err", err, 0);
        chk("t6_den_cnt", den_cnt, 2 * DEPTH);
        chk("t6_queue_empty", exp_q.size(), 0);

        // T7: async reset during WR_WAIT, then a clean rerun
        prep();
        drdy_min = 10; drdy_max = 10;
        expect_seq(1);
        do_start(1, s);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wr_den_seen) break;
        end
        chk("t7_write_reached", wr_den_seen, 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_busy", busy, 0);
        chk("t7_done", done, 0);
        chk("t7_err", err, 0);
        chk("t7_pll_rst", pll_rst, 0);
        chk("t7_den", drp_den, 0);
        chk("t7_dwe", drp_dwe, 0);
        chk("t7_daddr", drp_daddr, 0);
        chk("t7_di", drp_di, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        prep();
        drdy_min = 2; drdy_max = 2;
        expect_seq(1);
        do_start(1, s);
        chk_started("t7b");
        wait_done("t7b_done", 300, d);
        chk("t7b_err", err, 0);
        chk("t7b_den_cnt", den_cnt, 2);
        chk("t7b_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
